nco_phase_gen: RTL
==================

Name: nco_phase_gen

Overview:
Numerically controlled phase accumulator that generates the lookup addresses for the sine_wave ROM, directly upstream of it. Each sample strobe adds a frequency control word (FCW) to a wide phase accumulator. The top ADDR_WIDTH bits of the accumulator drive the ROM address. New FCWs are loaded through a valid/ready handshake, either immediately or with an exponential glide (portamento).

Parameters:
ACC_WIDTH, 32, phase accumulator and FCW width in bits
ADDR_WIDTH, 16, output address width; must be ≤ ACC_WIDTH
GLIDE_SHIFT, 4, glide rate; each glide step closes 1/2^GLIDE_SHIFT of the remaining FCW difference

Ports:
i_clk  in  1  system clock (5 MHz in the standard bench)
i_rst  in  1  synchronous reset, active-high
i_en  in  1  sample strobe; one accumulator step per cycle it is high
i_fcw  in  ACC_WIDTH  requested frequency control word, unsigned
i_fcw_valid  in  1  i_fcw is presented
o_fcw_ready  out  1  block can accept an FCW
i_glide_en  in  1  glide to the new FCW; sampled only on handshake
i_phase_sync  in  1  force phase to zero
o_addr  out  ADDR_WIDTH  ROM address = acc[ACC_WIDTH-1 -: ADDR_WIDTH]
o_addr_valid  out  1  one-cycle pulse marking a new o_addr
o_wrap  out  1  accumulator overflowed on this step; qualified by o_addr_valid
o_busy  out  1  glide in progress

Behaviour:
- Registers: r_acc (ACC_WIDTH), r_inc (current increment), r_target, FSM state {IDLE, GLIDE}.
- Reset (i_rst high at a clock edge): r_acc = r_inc = r_target = 0; state = IDLE; o_addr = 0; o_addr_valid = 0; o_wrap = 0. Reset overrides every other input, including mid-glide.
- o_fcw_ready = (state == IDLE) && !i_rst. This is combinational.
- o_busy = (state == GLIDE).
- Handshake: an FCW is accepted on a cycle where i_fcw_valid && o_fcw_ready. If i_fcw_valid is high while ready is low, nothing is accepted and the source must hold its value.
- IDLE, accept with i_glide_en = 0: r_inc <= i_fcw; stay in IDLE.
- IDLE, accept with i_glide_en = 1 and i_fcw != r_inc: r_target <= i_fcw; go to GLIDE.
- IDLE, accept with i_glide_en = 1 and i_fcw == r_inc: no change.
- GLIDE, on each cycle with i_en high:
  - diff = r_target − r_inc, computed signed at ACC_WIDTH+1 bits.
  - step = diff >>> GLIDE_SHIFT (arithmetic shift).
  - If step == 0: r_inc <= r_target and go to IDLE.
  - Otherwise: r_inc <= r_inc + step.
  - Glides in both directions. r_inc never overshoots the target.
- Accumulator step, on a cycle with i_en high:
  - r_acc <= r_acc + r_inc, modulo 2^ACC_WIDTH.
  - The add uses the r_inc value from before any same-cycle FCW load or glide update.
  - On the next cycle: o_addr = the new top bits, o_addr_valid = 1, o_wrap = carry-out of the add.
  - Latency from i_en to o_addr_valid is 1 cycle.
- i_phase_sync has priority over i_en on the same cycle:
  - r_acc <= 0; next cycle o_addr = 0, o_addr_valid = 1, o_wrap = 0.
  - r_inc and FSM state are unaffected; a glide continues if i_en is also high.
- i_en low and i_phase_sync low: o_addr holds its value; o_addr_valid = 0; o_wrap = 0.
- r_inc = 0 with i_en high: o_addr_valid still pulses with an unchanged address.
- Output frequency = f_en · r_inc / 2^ACC_WIDTH.

Test Plan:
1. Reset, then load i_fcw=0x00010000 with glide off, i_en held high → o_addr = 0x0001, 0x0002, ... one cycle after each strobe. After 65536 steps o_addr = 0x0000 with o_wrap = 1; o_wrap = 0 on every other step.
2. Load i_fcw=0x80000000, i_en high → o_addr alternates 0x8000, 0x0000. o_wrap = 1 on each 0x0000.
3. From r_inc=0, load i_fcw=0x00100000 with glide on, GLIDE_SHIFT=4 → r_inc = 0x00010000, then 0x0001F000, ..., strictly increasing, ending at exactly 0x00100000. o_busy and !o_fcw_ready hold throughout; a valid held during the glide is accepted only after return to IDLE.
4. Glide down from 0x00100000 to i_fcw=0 → r_inc decreases monotonically to exactly 0. Then o_addr stays constant while o_addr_valid still pulses.
5. Mid-run, assert i_phase_sync together with i_en → next cycle o_addr = 0, o_addr_valid = 1, o_wrap = 0. The following strobe gives o_addr = r_inc[31:16].
6. Assert i_rst mid-glide → the next cycle shows o_addr = 0, o_addr_valid = 0, o_busy = 0. o_fcw_ready = 0 while i_rst is high and 1 on the first cycle after release.

Source files
------------

// File: rtl/nco_phase_gen.sv
// Numerically controlled phase accumulator feeding the sine_wave ROM.
// Each sample strobe adds the current increment (FCW) to a wide phase
// accumulator; the top ADDR_WIDTH bits form the ROM address. New FCWs
// arrive on a valid/ready handshake and are applied either at once or
// through an exponential glide (portamento) toward the requested value.
//
// Handshake: an FCW transfers on any clock edge where i_fcw_valid and
// o_fcw_ready are both high. While ready is low the source keeps valid
// and i_fcw stable; nothing is consumed. Ready is low during a glide
// and while reset is asserted.
module nco_phase_gen #(
    parameter int ACC_WIDTH   = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int GLIDE_SHIFT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [ACC_WIDTH-1:0]  i_fcw,
    input  logic                  i_fcw_valid,
    output logic                  o_fcw_ready,
    input  logic                  i_glide_en,
    input  logic                  i_phase_sync,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_addr_valid,
    output logic                  o_wrap,
    output logic                  o_busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GLIDE = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [ACC_WIDTH-1:0]   r_inc;
    logic [ACC_WIDTH-1:0]   r_target;
    logic [ACC_WIDTH-1:0]   inc_next;
    logic [ACC_WIDTH-1:0]   target_next;
    logic [ACC_WIDTH:0]     acc_sum;
    logic signed [ACC_WIDTH:0] glide_diff;
    logic signed [ACC_WIDTH:0] glide_step;
    logic                   accept;

    assign o_fcw_ready = (state == IDLE) && !i_rst;
    assign o_busy      = (state == GLIDE);
    assign accept      = i_fcw_valid && o_fcw_ready;

    // The address is simply the top of the accumulator; it only moves on
    // a strobe or phase sync, so it holds naturally between strobes.
    assign o_addr = r_acc[ACC_WIDTH-1 -: ADDR_WIDTH];

    // Accumulator add with carry-out; always uses the pre-update increment.
    always_comb begin
        acc_sum    = {1'b0, r_acc} + {1'b0, r_inc};
        glide_diff = $signed({1'b0, r_target}) - $signed({1'b0, r_inc});
        glide_step = glide_diff >>> GLIDE_SHIFT;
    end

    // Next-state logic for the FCW load / glide controller.
    always_comb begin
        state_next  = state;
        inc_next    = r_inc;
        target_next = r_target;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!i_glide_en) begin
                        inc_next = i_fcw;
                    end else if (i_fcw != r_inc) begin
                        target_next = i_fcw;
                        state_next  = GLIDE;
                    end
                end
            end
            GLIDE: begin
                if (i_en) begin
                    // Arithmetic shift rounds toward -inf, so a downward
                    // glide finishes with unit steps and never undershoots.
                    if (glide_step == '0) begin
                        inc_next   = r_target;
                        state_next = IDLE;
                    end else begin
                        inc_next = r_inc + glide_step[ACC_WIDTH-1:0];
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Controller registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            r_inc    <= '0;
            r_target <= '0;
        end else begin
            state    <= state_next;
            r_inc    <= inc_next;
            r_target <= target_next;
        end
    end

    // Phase accumulator and output strobes; phase sync outranks the strobe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc        <= '0;
            o_addr_valid <= 1'b0;
            o_wrap       <= 1'b0;
        end else if (i_phase_sync) begin
            r_acc        <= '0;
            o_addr_valid <= 1'b1;
            o_wrap       <= 1'b0;
        end else if (i_en) begin
            r_acc        <= acc_sum[ACC_WIDTH-1:0];
            o_addr_valid <= 1'b1;
            o_wrap       <= acc_sum[ACC_WIDTH];
        end else begin
            o_addr_valid <= 1'b0;
            o_wrap       <= 1'b0;
        end
    end

endmodule
